// File: rtl/demux32_1_2_buf.sv
// demux32_1_2_buf
//   Buffered 1-to-2 demultiplexer. One word per cycle enters on a
//   valid/ready stream and is steered by Sel into one of two independent
//   2-entry FIFOs (A for Sel=0, B for Sel=1). Each FIFO drains to its own
//   valid/ready output. Order is preserved within each FIFO only.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   I, Sel, in_valid   : input word, destination select, input valid
//   in_ready           : selected FIFO has room (from registered counts only)
//   OA, a_valid        : head of FIFO A and its valid
//   a_ready            : consumer A takes OA this cycle
//   OB, b_valid, b_ready : same for FIFO B
//   a_count, b_count   : FIFO occupancies, 0..2
module demux32_1_2_buf #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] I,
    input  logic             Sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] OA,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] OB,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [1:0]       a_count,
    output logic [1:0]       b_count
);

    localparam int unsigned DEPTH = 2;

    // Index 0 is FIFO A, index 1 is FIFO B.
    logic [WIDTH-1:0] mem  [2][DEPTH];
    logic [WIDTH-1:0] head [2];
    logic [1:0]       cnt  [2];
    logic             rptr [2];
    logic             wptr [2];
    logic             push [2];
    logic             pop  [2];
    logic             rdy  [2];

    always_comb begin
        rdy[0]   = a_ready;
        rdy[1]   = b_ready;
        // Never looks at the output readys: a full FIFO refuses even when
        // it is being popped in the same cycle.
        in_ready = Sel ? (cnt[1] != 2'd2) : (cnt[0] != 2'd2);
        for (int unsigned i = 0; i < 2; i++) begin
            push[i] = in_valid && in_ready && (Sel == 1'(i));
            pop[i]  = (cnt[i] != 2'd0) && rdy[i];
        end
    end

    // The head word is kept in its own register so the output holds its
    // last value when the FIFO empties, and never changes on a push to a
    // non-empty FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                cnt[i]  <= '0;
                rptr[i] <= 1'b0;
                wptr[i] <= 1'b0;
                head[i] <= '0;
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    mem[i][j] <= '0;
                end
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (push[i]) begin
                    mem[i][wptr[i]] <= I;
                    wptr[i]         <= ~wptr[i];
                end
                if (pop[i]) begin
                    rptr[i] <= ~rptr[i];
                end

                case ({push[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + 2'd1;
                    2'b01:   cnt[i] <= cnt[i] - 2'd1;
                    default: cnt[i] <= cnt[i];
                endcase

                if (pop[i]) begin
                    if (cnt[i] == 2'd2) begin
                        head[i] <= mem[i][~rptr[i]];
                    end else if (push[i]) begin
                        head[i] <= I;
                    end
                end else if ((cnt[i] == 2'd0) && push[i]) begin
                    head[i] <= I;
                end
            end
        end
    end

    assign OA      = head[0];
    assign OB      = head[1];
    assign a_valid = (cnt[0] != 2'd0);
    assign b_valid = (cnt[1] != 2'd0);
    assign a_count = cnt[0];
    assign b_count = cnt[1];

endmodule

// File: tb/tb_demux32_1_2_buf.sv
// tb_demux32_1_2_buf
//   Directed stimulus for demux32_1_2_buf. A queue-based model of the two
//   FIFOs is checked against the DUT on every falling edge, and literal
//   expectations pin the key scenarios.
module tb_demux32_1_2_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] I = '0;
    logic        Sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] OA, OB;
    logic        a_valid, b_valid;
    logic        a_ready = 1'b0;
    logic        b_ready = 1'b0;
    logic [1:0]  a_count, b_count;

    int n_total = 0;
    int n_pass  = 0;

    demux32_1_2_buf #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .I(I), .Sel(Sel), .in_valid(in_valid),
        .in_ready(in_ready), .OA(OA), .a_valid(a_valid), .a_ready(a_ready),
        .OB(OB), .b_valid(b_valid), .b_ready(b_ready),
        .a_count(a_count), .b_count(b_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: two bounded queues plus the last head seen.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] m_oa = '0;
    logic [31:0] m_ob = '0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            m_oa = '0;
            m_ob = '0;
            started = 1'b1;
        end else begin
            bit acc, pa, pb;
            acc = in_valid && (Sel ? (qb.size() < 2) : (qa.size() < 2));
            pa  = (qa.size() > 0) && a_ready;
            pb  = (qb.size() > 0) && b_ready;
            if (pa) void'(qa.pop_front());
            if (pb) void'(qb.pop_front());
            if (acc) begin
                if (Sel) qb.push_back(I);
                else     qa.push_back(I);
            end
            if (qa.size() > 0) m_oa = qa[0];
            if (qb.size() > 0) m_ob = qb[0];
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_in_ready", 32'(in_ready), 32'(Sel ? (qb.size() < 2) : (qa.size() < 2)));
            check("m_a_valid", 32'(a_valid), 32'(qa.size() > 0));
            check("m_b_valid", 32'(b_valid), 32'(qb.size() > 0));
            check("m_a_count", 32'(a_count), 32'(qa.size()));
            check("m_b_count", 32'(b_count), 32'(qb.size()));
            check("m_OA", OA, m_oa);
            check("m_OB", OB, m_ob);
        end
    end

    // Inputs change at posedge+2; literal checks run at posedge+3 and see
    // the post-edge state with the next word already presented.
    task automatic set(input logic iv, input logic sel, input logic [31:0] d,
                       input logic ar, input logic br);
        in_valid = iv;
        Sel      = sel;
        I        = d;
        a_ready  = ar;
        b_ready  = br;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        set(0, 0, 0, 1, 1);
        // reset state
        check("rst_a_valid", 32'(a_valid), 0);
        check("rst_b_valid", 32'(b_valid), 0);
        check("rst_OA", OA, 0);
        check("rst_OB", OB, 0);
        check("rst_a_count", 32'(a_count), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // basic steer
        set(1, 0, 4, 1, 1); step();
        check("steer_OA", OA, 4);
        check("steer_a_valid", 32'(a_valid), 1);
        check("steer_b_idle", 32'(b_valid), 0);
        set(1, 1, 16, 1, 1); step();
        check("steer_a_gone", 32'(a_valid), 0);
        check("steer_OB", OB, 16);
        check("steer_b_valid", 32'(b_valid), 1);
        set(0, 0, 0, 1, 1); step();
        check("steer_b_gone", 32'(b_valid), 0);

        // fill and stall
        set(1, 0, 1, 0, 1); step();
        set(1, 0, 2, 0, 1); step();
        check("fill_a_count", 32'(a_count), 2);
        check("fill_OA", OA, 1);
        set(1, 0, 3, 0, 1);
        check("fill_in_ready0", 32'(in_ready), 0);
        step();
        check("fill_hold_count", 32'(a_count), 2);
        set(1, 0, 3, 1, 1);
        check("fill_pop_no_pass", 32'(in_ready), 0);
        step();
        check("fill_OA2", OA, 2);
        check("fill_in_ready1", 32'(in_ready), 1);
        step();
        check("fill_OA3", OA, 3);
        check("fill_count1", 32'(a_count), 1);
        set(0, 0, 0, 1, 1); step();
        check("fill_drained", 32'(a_count), 0);

        // cross-port independence
        set(1, 0, 11, 0, 0); step();
        set(1, 0, 12, 0, 0); step();
        set(1, 1, 7, 0, 0);
        check("cross_in_ready", 32'(in_ready), 1);
        step();
        check("cross_OB", OB, 7);
        check("cross_b_count", 32'(b_count), 1);
        check("cross_OA", OA, 11);
        check("cross_a_count", 32'(a_count), 2);
        set(0, 0, 0, 1, 1); step();
        check("cross_OA12", OA, 12);
        step();
        check("cross_empty_a", 32'(a_count), 0);
        check("cross_empty_b", 32'(b_count), 0);

        // push and pop together at count 1 on B
        set(1, 1, 5, 1, 0); step();
        check("pp_OB5", OB, 5);
        set(1, 1, 6, 1, 1); step();
        check("pp_b_count", 32'(b_count), 1);
        check("pp_OB6", OB, 6);
        set(0, 0, 0, 1, 1); step();

        // mid-stream reset
        set(1, 0, 8, 0, 0); step();
        set(1, 0, 9, 0, 0); step();
        set(1, 1, 10, 0, 0); step();
        check("mr_a_count", 32'(a_count), 2);
        check("mr_b_count", 32'(b_count), 1);
        rst = 1'b1;
        set(1, 1, 32'h55, 1, 1); step();
        rst = 1'b0;
        set(0, 0, 0, 1, 1);
        check("mr_a_valid", 32'(a_valid), 0);
        check("mr_b_valid", 32'(b_valid), 0);
        check("mr_a_count0", 32'(a_count), 0);
        check("mr_b_count0", 32'(b_count), 0);
        check("mr_OA", OA, 0);
        check("mr_OB", OB, 0);
        step();
        check("mr_no_ghost", 32'(b_valid), 0);

        // stability under pushes while stalled
        set(1, 0, 32'hDEADBEEF, 0, 0); step();
        for (int k = 0; k < 3; k++) begin
            set(1, 0, 32'(100 + k), 0, 0); step();
            check("stab_OA", OA, 32'hDEADBEEF);
            check("stab_a_valid", 32'(a_valid), 1);
        end
        set(0, 0, 0, 1, 1); step(); step(); step();
        check("stab_drained", 32'(a_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
